// File: rtl/ball_renderer.sv
// ball_renderer: ball/paddle/background pixel generator with per-frame ball FSM; define BALL_BORDER_EN to draw a grey screen border
module ball_renderer #(
    parameter int H_RES        = 1280,
    parameter int V_RES        = 1024,
    parameter int SIZE         = 16,
    parameter int SPEED        = 4,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 128,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] col,
    input  logic [10:0] row,
    input  logic        visible,
    input  logic        vsync,
    input  logic [1:0]  seed,
    input  logic [10:0] pad_top,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hit,
    output logic [7:0]  score
);
    localparam logic [11:0] XC = 12'((H_RES - SIZE) / 2);
    localparam logic [11:0] XMAX = 12'(H_RES - SIZE);
    localparam logic [11:0] XLIM = 12'(PAD_W + SPEED);
    localparam logic [11:0] SZX = 12'(SIZE);
    localparam logic [11:0] SPX = 12'(SPEED);
    localparam logic [11:0] PWX = 12'(PAD_W);
    localparam logic [10:0] YC = 11'((V_RES - SIZE) / 2);
    localparam logic [10:0] YMAX = 11'(V_RES - SIZE);
    localparam logic [10:0] SZY = 11'(SIZE);
    localparam logic [10:0] SPY = 11'(SPEED);
    localparam logic [10:0] PH = 11'(PAD_H);
    localparam logic [10:0] PMAX = 11'(V_RES - PAD_H);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [15:0] MISS_LAST = 16'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {SERVE = 2'd0, MOVE = 2'd1, MISS = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic        vs_q, vs_d;
    logic        hit_q, hit_d;
    logic [7:0]  score_q, score_d;
    logic        in_ball_q, in_ball_d, in_pad_q, in_pad_d, vis_q, vis_d;
    logic [23:0] rgb_q, rgb_d;
`ifdef BALL_BORDER_EN
    logic        border_q, border_d;
`endif

    logic        tick;
    logic [10:0] pad_c;
    logic        overlap;

    assign tick    = vs_q & ~vsync;
    assign pad_c   = (pad_top > PMAX) ? PMAX : pad_top;
    assign overlap = (y_q + SZY > pad_c) && (y_q < pad_c + PH);
    assign vs_d    = vsync;

    // Ball FSM: everything advances only on the frame tick; both axes resolve from the pre-update y
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hit_d   = 1'b0;
        score_d = score_q;
        if (tick) begin
            case (state_q)
                SERVE: begin
                    x_d     = XC;
                    y_d     = YC;
                    dx_d    = seed[0];
                    dy_d    = seed[1];
                    cnt_d   = (cnt_q == SERVE_LAST) ? 16'd0 : cnt_q + 16'd1;
                    state_d = (cnt_q == SERVE_LAST) ? MOVE : SERVE;
                end
                MOVE: begin
                    if (dy_q && y_q + SPY >= YMAX) begin
                        y_d  = YMAX;
                        dy_d = 1'b0;
                    end else if (!dy_q && y_q < SPY) begin
                        y_d  = 11'd0;
                        dy_d = 1'b1;
                    end else begin
                        y_d = dy_q ? y_q + SPY : y_q - SPY;
                    end
                    if (dx_q && x_q + SPX >= XMAX) begin
                        x_d  = XMAX;
                        dx_d = 1'b0;
                    end else if (!dx_q && x_q < XLIM) begin
                        if (overlap) begin
                            x_d     = PWX;
                            dx_d    = 1'b1;
                            hit_d   = 1'b1;
                            score_d = (&score_q) ? score_q : score_q + 8'd1;
                        end else begin
                            state_d = MISS;
                            cnt_d   = 16'd0;
                            score_d = 8'd0;
                        end
                    end else begin
                        x_d = dx_q ? x_q + SPX : x_q - SPX;
                    end
                end
                default: begin
                    cnt_d   = (cnt_q == MISS_LAST) ? 16'd0 : cnt_q + 16'd1;
                    state_d = (cnt_q == MISS_LAST) ? SERVE : MISS;
                    x_d     = (cnt_q == MISS_LAST) ? XC : x_q;
                    y_d     = (cnt_q == MISS_LAST) ? YC : y_q;
                end
            endcase
        end
    end

    // Two-stage pixel pipeline: stage 1 classifies the coordinate, stage 2 picks the colour by priority
    always_comb begin
        in_ball_d = (col >= x_q) && (col < x_q + SZX) && (row >= y_q) && (row < y_q + SZY);
        in_pad_d  = (col < PWX) && (row >= pad_c) && (row < pad_c + PH);
        vis_d     = visible;
`ifdef BALL_BORDER_EN
        border_d  = (col < 12'd2) || (col >= 12'(H_RES - 2)) || (row < 11'd2) || (row >= 11'(V_RES - 2));
`endif
        rgb_d = !vis_q ? 24'h000000 :
                in_ball_q ? ((state_q == MISS) ? 24'hFF0000 : 24'hFFFFFF) :
                in_pad_q ? 24'h0000FF :
`ifdef BALL_BORDER_EN
                border_q ? 24'h808080 :
`endif
                24'h00FF00;
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SERVE;
            cnt_q     <= 16'd0;
            x_q       <= XC;
            y_q       <= YC;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
            vs_q      <= 1'b1;
            hit_q     <= 1'b0;
            score_q   <= 8'd0;
            in_ball_q <= 1'b0;
            in_pad_q  <= 1'b0;
            vis_q     <= 1'b0;
            rgb_q     <= 24'h000000;
`ifdef BALL_BORDER_EN
            border_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            vs_q      <= vs_d;
            hit_q     <= hit_d;
            score_q   <= score_d;
            in_ball_q <= in_ball_d;
            in_pad_q  <= in_pad_d;
            vis_q     <= vis_d;
            rgb_q     <= rgb_d;
`ifdef BALL_BORDER_EN
            border_q  <= border_d;
`endif
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hit   = hit_q;
    assign score = score_q;
endmodule

// File: tb/tb_ball_renderer.sv
// tb_ball_renderer: pixel vector table with a latency scoreboard plus a reference ball model driven tick by tick
module tb_ball_renderer;
    logic        clock, reset, visible, vsync, hit;
    logic [11:0] col;
    logic [10:0] row, pad_top;
    logic [1:0]  seed;
    logic [7:0]  red, green, blue, score;

    ball_renderer dut (
        .clock(clock), .reset(reset), .col(col), .row(row), .visible(visible),
        .vsync(vsync), .seed(seed), .pad_top(pad_top),
        .red(red), .green(green), .blue(blue), .hit(hit), .score(score)
    );

`ifdef BALL_BORDER_EN
    localparam logic [23:0] BRD = 24'h808080;
`else
    localparam logic [23:0] BRD = 24'h00FF00;
`endif

    typedef struct {
        logic [11:0] c;
        logic [10:0] r;
        logic        v;
        logic [10:0] pt;
        logic [23:0] e;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [23:0] e;
    } exp_t;

    vec_t tbl[21];
    exp_t sbq[$];
    int   ntests = 0, nfail = 0, cyc = 0;
    int   m_st, m_cnt, m_x, m_y, m_dx, m_dy, m_score;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // scoreboard: pop the expected colour exactly two clocks after its coordinate was driven
    always @(negedge clock) begin
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
            exp_t x;
            x = sbq.pop_front();
            ntests++;
            if ({red, green, blue} !== x.e) begin
                nfail++;
                $display("FAIL pix[%0d]: got %06h expected %06h", x.id, {red, green, blue}, x.e);
            end
        end
    end

    task automatic pix(input int c, input int r, input logic v, input int pt, input logic [23:0] e, input int id);
        col = 12'(c);
        row = 11'(r);
        visible = v;
        pad_top = 11'(pt);
        sbq.push_back('{cyc + 2, id, e});
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_x = 632; m_y = 504; m_dx = 0; m_dy = 0; m_score = 0;
    endtask

    function automatic int track();
        return (m_y >= 50) ? m_y - 50 : 0;
    endfunction

    task automatic tick(input logic [1:0] s, input int pt);
        int pc, ny, ndy;
        logic eh;
        eh = 1'b0;
        seed = s;
        pad_top = 11'(pt);
        vsync = 1'b0;
        pc = (pt > 896) ? 896 : pt;
        case (m_st)
            0: begin
                m_x = 632; m_y = 504; m_dx = int'(s[0]); m_dy = int'(s[1]);
                if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end else m_cnt++;
            end
            1: begin
                if (m_dy == 1 && m_y + 4 >= 1008) begin ny = 1008; ndy = 0; end
                else if (m_dy == 0 && m_y < 4) begin ny = 0; ndy = 1; end
                else begin ny = (m_dy == 1) ? m_y + 4 : m_y - 4; ndy = m_dy; end
                if (m_dx == 1 && m_x + 4 >= 1264) begin m_x = 1264; m_dx = 0; end
                else if (m_dx == 0 && m_x < 12) begin
                    if (m_y + 16 > pc && m_y < pc + 128) begin
                        m_x = 8; m_dx = 1; eh = 1'b1;
                        m_score = (m_score == 255) ? 255 : m_score + 1;
                    end else begin
                        m_st = 2; m_cnt = 0; m_score = 0;
                    end
                end else m_x = (m_dx == 1) ? m_x + 4 : m_x - 4;
                m_y = ny; m_dy = ndy;
            end
            default: begin
                if (m_cnt == 59) begin m_st = 0; m_cnt = 0; m_x = 632; m_y = 504; end else m_cnt++;
            end
        endcase
        @(posedge clock);
        #1;
        vsync = 1'b1;
        chk("hit", hit, eh);
        chk("ball", {dut.state_q, dut.x_q, dut.y_q, dut.dx_q, dut.dy_q, score},
            {2'(m_st), 12'(m_x), 11'(m_y), 1'(m_dx), 1'(m_dy), 8'(m_score)});
        @(posedge clock);
        #1;
        chk("hit_off", hit, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1; vsync = 1'b1; visible = 1'b0; col = '0; row = '0; seed = '0; pad_top = '0;
        tbl[0]  = '{12'd632,  11'd504,  1'b1, 11'd450,  24'hFFFFFF};
        tbl[1]  = '{12'd647,  11'd519,  1'b1, 11'd450,  24'hFFFFFF};
        tbl[2]  = '{12'd648,  11'd519,  1'b1, 11'd450,  24'h00FF00};
        tbl[3]  = '{12'd631,  11'd504,  1'b1, 11'd450,  24'h00FF00};
        tbl[4]  = '{12'd632,  11'd520,  1'b1, 11'd450,  24'h00FF00};
        tbl[5]  = '{12'd632,  11'd503,  1'b1, 11'd450,  24'h00FF00};
        tbl[6]  = '{12'd640,  11'd510,  1'b0, 11'd450,  24'h000000};
        tbl[7]  = '{12'd0,    11'd450,  1'b1, 11'd450,  24'h0000FF};
        tbl[8]  = '{12'd7,    11'd577,  1'b1, 11'd450,  24'h0000FF};
        tbl[9]  = '{12'd8,    11'd500,  1'b1, 11'd450,  24'h00FF00};
        tbl[10] = '{12'd0,    11'd578,  1'b1, 11'd450,  BRD};
        tbl[11] = '{12'd0,    11'd449,  1'b1, 11'd450,  BRD};
        tbl[12] = '{12'd1279, 11'd1023, 1'b1, 11'd450,  BRD};
        tbl[13] = '{12'd640,  11'd1,    1'b1, 11'd450,  BRD};
        tbl[14] = '{12'd1278, 11'd500,  1'b1, 11'd450,  BRD};
        tbl[15] = '{12'd2,    11'd2,    1'b1, 11'd450,  24'h00FF00};
        tbl[16] = '{12'd1277, 11'd1021, 1'b1, 11'd450,  24'h00FF00};
        tbl[17] = '{12'd0,    11'd1000, 1'b1, 11'd2000, 24'h0000FF};
        tbl[18] = '{12'd0,    11'd895,  1'b1, 11'd2000, BRD};
        tbl[19] = '{12'd3,    11'd896,  1'b1, 11'd1500, 24'h0000FF};
        tbl[20] = '{12'd0,    11'd0,    1'b0, 11'd0,    24'h000000};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_rgb", {red, green, blue}, 24'h0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_ball", {dut.state_q, dut.x_q, dut.y_q, dut.dx_q, dut.dy_q, score},
            {2'd0, 12'd632, 11'd504, 1'b0, 1'b0, 8'd0});
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;

        for (int i = 0; i < 21; i++) pix(tbl[i].c, tbl[i].r, tbl[i].v, tbl[i].pt, tbl[i].e, i);
        repeat (3) @(posedge clock);
        #1;

        for (int i = 0; i < 60; i++) tick(2'b11, 450);
        chk("serve_done", {dut.state_q, dut.x_q, dut.y_q}, {2'd1, 12'd632, 11'd504});
        tick(2'b11, 450);
        chk("move1", {dut.x_q, dut.y_q}, {12'd636, 11'd508});

        n = 0;
        while (m_score < 3 && n < 3000) begin tick(2'b00, track()); n++; end
        chk("rally_score", score, 8'd3);
        pix(m_x, m_y, 1'b1, 1500, 24'hFFFFFF, 100);
        pix(m_x + 15, m_y + 15, 1'b1, 1500, 24'hFFFFFF, 101);

        n = 0;
        while (m_st == 1 && n < 3000) begin
            tick(2'b00, (m_dx == 0 && m_x < 12) ? m_y + 16 : track());
            n++;
        end
        chk("miss_state", {dut.state_q, score}, {2'd2, 8'd0});
        pix(m_x, m_y, 1'b1, 1500, 24'hFF0000, 102);
        pix(m_x + 15, m_y + 15, 1'b1, 1500, 24'hFF0000, 103);
        pix(m_x + 16, m_y, 1'b1, 1500, 24'h00FF00, 104);
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 60; i++) tick(2'b00, 0);
        chk("reserve", {dut.state_q, dut.x_q, dut.y_q}, {2'd0, 12'd632, 11'd504});

        for (int i = 0; i < 60; i++) tick(2'b00, 0);
        n = 0;
        while (m_score < 1 && n < 3000) begin tick(2'b00, track()); n++; end
        repeat (3) tick(2'b00, track());
        col = 12'd100; row = 11'd100; visible = 1'b1; pad_top = 11'd800;
        repeat (3) @(posedge clock);
        #1;
        chk("pre_rst_rgb", {red, green, blue}, 24'h00FF00);
        chk("pre_rst_move", {dut.state_q, score}, {2'd1, 8'd1});
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst", {dut.state_q, score, red, green, blue, hit}, {2'd0, 8'd0, 24'h0, 1'b0});
        reset = 1'b0;
        model_reset();
        tick(2'b10, 0);
        pix(0, 500, 1'b1, 0, BRD, 105);
        pix(632, 504, 1'b1, 0, 24'hFFFFFF, 106);
        repeat (4) @(posedge clock);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
